// File: rtl/mcs4_io_capture.sv
// rtl/mcs4_io_capture.sv - change-detecting capture of ROM/RAM output ports into a timestamped event FIFO
// Ports are prioritised ROM 0..NUM_ROMS-1 then RAM 0..NUM_RAM_PORTS-1; at most one event is enqueued per cycle.
module mcs4_io_capture #(
   parameter int NUM_ROMS      = 16,
   parameter int NUM_RAM_PORTS = 16,
   parameter int DEPTH         = 16,
   parameter int TS_WIDTH      = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_ROMS*4-1:0]      rom_dout,
   input  logic [NUM_RAM_PORTS*4-1:0] ram_dout,
   input  logic                       enable,
   input  logic                       clear,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic                       ev_src,
   output logic [3:0]                 ev_index,
   output logic [3:0]                 ev_data,
   output logic [TS_WIDTH-1:0]        ev_ts,
   output logic [15:0]                coalesce_count
);
   localparam int NP = NUM_ROMS + NUM_RAM_PORTS;
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 9 + TS_WIDTH;

   typedef enum logic {INIT, RUN} state_t;
   state_t state;

   logic [NP*4-1:0]     raw, in_q, last_rep;
   logic [TS_WIDTH-1:0] ts;
   logic [EW-1:0]       mem [DEPTH];
   logic [EW-1:0]       head, entry;
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [AW:0]         count;
   logic [NP-1:0]       pending;
   logic                any_pend, full, enq, deq, coal;
   logic [4:0]          sel, rel;
   logic                sel_src;

   assign raw = {ram_dout, rom_dout};

   // Descending scan so the lowest pending index is the one left in sel.
   always_comb begin
      any_pend = 1'b0;
      sel      = '0;
      for (int p = NP - 1; p >= 0; p--) begin
         pending[p] = (in_q[p*4 +: 4] != last_rep[p*4 +: 4]);
         if (pending[p]) begin
            any_pend = 1'b1;
            sel      = 5'(p);
         end
      end
   end

   assign full    = (count == (AW+1)'(DEPTH));
   assign enq     = (state == RUN) && enable && !full && any_pend && !clear;
   assign deq     = ev_valid && ev_ready && !clear;
   assign sel_src = (sel >= 5'(NUM_ROMS));
   assign rel     = sel_src ? sel - 5'(NUM_ROMS) : sel;
   assign entry   = {sel_src, rel[3:0], in_q[int'(sel)*4 +: 4], ts};

   // One coalesce cycle no matter how many ports were overwritten at once.
   always_comb begin
      coal = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (raw[p*4 +: 4] != in_q[p*4 +: 4] && pending[p] && !(enq && sel == 5'(p)))
            coal = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      in_q <= raw;
      if (rst) begin
         state          <= INIT;
         ts             <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         coalesce_count <= '0;
      end else begin
         ts <= ts + 1'b1;
         if (clear) begin
            state          <= INIT;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            coalesce_count <= '0;
         end else begin
            case (state)
               INIT: begin
                  last_rep <= raw;
                  state    <= RUN;
               end
               RUN: begin
                  if (!enable)
                     last_rep <= in_q;
                  else if (enq)
                     last_rep[int'(sel)*4 +: 4] <= in_q[int'(sel)*4 +: 4];
                  if (coal && coalesce_count != 16'hFFFF)
                     coalesce_count <= coalesce_count + 16'd1;
               end
               default: state <= INIT;
            endcase
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= entry;
   end

   // Fields read as zero while empty so reset and flushed states look clean.
   assign head     = mem[rd_ptr];
   assign ev_valid = (count != '0);
   assign ev_src   = ev_valid & head[EW-1];
   assign ev_index = ev_valid ? head[EW-2 -: 4] : 4'd0;
   assign ev_data  = ev_valid ? head[EW-6 -: 4] : 4'd0;
   assign ev_ts    = ev_valid ? head[TS_WIDTH-1:0] : '0;
endmodule
